// File: rtl/time_display_scan_if.sv
// Bundle between the clock top level and the display scan driver: time/status
// words in, two seven-segment banks out.
interface time_display_scan_if;
    logic [19:0] time_data;
    logic [5:0]  state_info;
    logic [6:0]  led0;
    logic [6:0]  led1;
    logic [3:0]  led_mux0;
    logic [3:0]  led_mux1;
    logic        dp0;
    logic        dp1;

    modport master (
        output time_data, state_info,
        input  led0, led1, led_mux0, led_mux1, dp0, dp1
    );

    modport slave (
        input  time_data, state_info,
        output led0, led1, led_mux0, led_mux1, dp0, dp1
    );
endinterface

// File: rtl/time_display_scan.sv
// Scans both 4-digit seven-segment banks in lockstep; inputs are shadowed once
// per frame and the SELECT menu digit blinks while the top level is in SELECT.
module time_display_scan #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FRAME_HZ = 250,
    parameter int BLINK_HZ = 2
) (
    input  logic               clk_sys,
    input  logic               rstn,
    time_display_scan_if.slave disp
);
    localparam int DIV    = CLK_HZ / (4 * FRAME_HZ);
    localparam int BDIV   = CLK_HZ / (2 * BLINK_HZ);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BDIV_W = (BDIV > 1) ? $clog2(BDIV) : 1;
    localparam logic [2:0] ST_SELECT = 3'd4;

    logic [DIV_W-1:0]  div_cnt_reg;
    logic [1:0]        idx_reg;
    logic [BDIV_W-1:0] blink_cnt_reg;
    logic              blink_reg;
    logic [19:0]       time_sh_reg;
    logic [5:0]        state_sh_reg;
    logic [6:0]        led0_reg;
    logic [6:0]        led1_reg;
    logic [3:0]        mux_reg;
    logic              dp0_reg;
    logic              dp1_reg;

    logic              div_wrap;
    logic              blink_wrap;
    logic [3:0]        bank1_val [4];
    logic [3:0]        bank0_val [4];
    logic [6:0]        bank1_seg [4];
    logic [6:0]        bank0_seg [4];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h40;
        endcase
    endfunction

    assign div_wrap   = (div_cnt_reg == DIV_W'(DIV - 1));
    assign blink_wrap = (blink_cnt_reg == BDIV_W'(BDIV - 1));

    // Digit map, index 0 is the rightmost digit of each bank.
    assign bank1_val[0] = time_sh_reg[10:7];
    assign bank1_val[1] = {1'b0, time_sh_reg[13:11]};
    assign bank1_val[2] = time_sh_reg[17:14];
    assign bank1_val[3] = {2'b00, time_sh_reg[19:18]};
    assign bank0_val[0] = time_sh_reg[3:0];
    assign bank0_val[1] = {1'b0, time_sh_reg[6:4]};
    assign bank0_val[2] = {1'b0, state_sh_reg[5:3]};
    assign bank0_val[3] = {1'b0, state_sh_reg[2:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign bank1_seg[gi] = seg7(bank1_val[gi]);
            if (gi == 2) begin : g_select
                assign bank0_seg[gi] = (state_sh_reg[2:0] == ST_SELECT && !blink_reg)
                                       ? seg7(bank0_val[gi]) : 7'h00;
            end else if (gi == 3) begin : g_state
                // Only codes 0..4 are defined states; anything above is shown as a dash.
                assign bank0_seg[gi] = (state_sh_reg[2:0] > ST_SELECT)
                                       ? 7'h40 : seg7(bank0_val[gi]);
            end else begin : g_num
                assign bank0_seg[gi] = seg7(bank0_val[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            div_cnt_reg   <= '0;
            idx_reg       <= 2'd0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
            time_sh_reg   <= '0;
            state_sh_reg  <= '0;
            led0_reg      <= 7'h00;
            led1_reg      <= 7'h00;
            mux_reg       <= 4'b0000;
            dp0_reg       <= 1'b0;
            dp1_reg       <= 1'b0;
        end else begin
            div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + 1'b1;
            if (div_wrap) begin
                idx_reg <= idx_reg + 2'd1;
            end
            // Frame boundary: latch inputs so a ripple never tears across a frame.
            if (div_wrap && idx_reg == 2'd3) begin
                time_sh_reg  <= disp.time_data;
                state_sh_reg <= disp.state_info;
            end

            blink_cnt_reg <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
            if (blink_wrap) begin
                blink_reg <= ~blink_reg;
            end

            led0_reg <= bank0_seg[idx_reg];
            led1_reg <= bank1_seg[idx_reg];
            mux_reg  <= 4'b0001 << idx_reg;
            dp1_reg  <= (idx_reg == 2'd0) || (idx_reg == 2'd2);
            dp0_reg  <= (idx_reg == 2'd2);
        end
    end

    assign disp.led0     = led0_reg;
    assign disp.led1     = led1_reg;
    assign disp.led_mux0 = mux_reg;
    assign disp.led_mux1 = mux_reg;
    assign disp.dp0      = dp0_reg;
    assign disp.dp1      = dp1_reg;
endmodule

// File: tb/tb_time_display_scan.sv
// Randomized bench for time_display_scan: a cycle-count reference model queues
// the expected display for every edge and a monitor compares on the falling edge.
module tb_time_display_scan;
    localparam int CLK_HZ   = 400;
    localparam int FRAME_HZ = 10;
    localparam int BLINK_HZ = 10;
    localparam int DIV      = CLK_HZ / (4 * FRAME_HZ);
    localparam int BDIV     = CLK_HZ / (2 * BLINK_HZ);
    localparam int FRAME    = 4 * DIV;

    typedef struct packed {
        logic [6:0] led1;
        logic [6:0] led0;
        logic [3:0] mux1;
        logic [3:0] mux0;
        logic       dp1;
        logic       dp0;
    } out_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    time_display_scan_if dif();

    time_display_scan #(
        .CLK_HZ  (CLK_HZ),
        .FRAME_HZ(FRAME_HZ),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk_sys(clk),
        .rstn   (rstn),
        .disp   (dif)
    );

    always #5 clk = ~clk;

    out_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [19:0] sh_time = '0;
    logic [5:0]  sh_state = '0;
    logic [6:0]  seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] dec(input int v);
        return (v <= 9) ? seg_tbl[v] : 7'h40;
    endfunction

    // Expected display after n clean edges have elapsed since reset release.
    function automatic out_t model_out(input int n, input logic [19:0] t, input logic [5:0] s);
        out_t o;
        int d     = (n / DIV) % 4;
        int phase = (n / BDIV) % 2;
        int sec_l = int'(t[3:0]);
        int sec_h = int'(t[6:4]);
        int min_l = int'(t[10:7]);
        int min_h = int'(t[13:11]);
        int hou_l = int'(t[17:14]);
        int hou_h = int'(t[19:18]);
        int st    = int'(s[2:0]);
        int sel   = int'(s[5:3]);
        int b1[4];
        b1[0] = min_l; b1[1] = min_h; b1[2] = hou_l; b1[3] = hou_h;
        o.led1 = dec(b1[d]);
        case (d)
            0:       o.led0 = dec(sec_l);
            1:       o.led0 = dec(sec_h);
            2:       o.led0 = (st == 4 && phase == 0) ? dec(sel) : 7'h00;
            default: o.led0 = (st <= 4) ? dec(st) : 7'h40;
        endcase
        o.mux0 = 4'(1 << d);
        o.mux1 = 4'(1 << d);
        o.dp1  = (d == 0) || (d == 2);
        o.dp0  = (d == 2);
        return o;
    endfunction

    function automatic out_t get_out();
        return out_t'({dif.led1, dif.led0, dif.led_mux1, dif.led_mux0, dif.dp1, dif.dp0});
    endfunction

    task automatic compare(input out_t got, input out_t want, input string name);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Reference model: one expected entry per rising edge.
    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            edge_n   = 0;
            sh_time  = '0;
            sh_state = '0;
        end else begin
            sb.push_back(model_out(edge_n, sh_time, sh_state));
            if ((edge_n + 1) % FRAME == 0) begin
                sh_time  = dif.time_data;
                sh_state = dif.state_info;
            end
            edge_n++;
        end
    end

    // Monitor: compares the presented display on every falling edge.
    initial begin
        out_t exp_o;
        logic [3:0] prev_mux = 4'hF;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                compare(get_out(), '0, "reset_value");
            end else if (sb.size() > 0) begin
                exp_o = sb.pop_front();
                compare(get_out(), exp_o, "scan");
                if (exp_o.mux0 != prev_mux) begin
                    $display("digit t=%0t mux=%b led1=%h led0=%h dp1=%b dp0=%b",
                             $time, dif.led_mux0, dif.led1, dif.led0, dif.dp1, dif.dp0);
                end
                prev_mux = exp_o.mux0;
            end
        end
    end

    function automatic logic [19:0] pack_time(input logic [1:0] hh, input logic [3:0] hl,
                                              input logic [2:0] mh, input logic [3:0] ml,
                                              input logic [2:0] sh, input logic [3:0] sl);
        return {hh, hl, mh, ml, sh, sl};
    endfunction

    task automatic wait_frame_pos(input int p);
        do @(negedge clk); while (edge_n % FRAME != p);
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic random_phase(input int iters);
        for (int i = 0; i < iters; i++) begin
            repeat ($urandom_range(1, 50)) @(negedge clk);
            dif.time_data  = 20'($urandom);
            dif.state_info = 6'($urandom);
        end
    endtask

    initial begin
        dif.time_data  = '0;
        dif.state_info = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        run_frames(2);

        // 23:59:48 with SELECT pending choice 2
        wait_frame_pos(5);
        dif.time_data  = pack_time(2'd2, 4'd3, 3'd5, 4'd9, 3'd4, 4'd8);
        dif.state_info = {3'd2, 3'd4};
        run_frames(3);

        // mid-frame change must wait for the next boundary
        wait_frame_pos(15);
        dif.time_data = pack_time(2'd1, 4'd7, 3'd2, 4'd6, 3'd3, 4'd1);
        run_frames(2);

        dif.state_info = {3'd2, 3'd1};
        run_frames(2);

        // invalid sec_l and state code
        dif.time_data  = pack_time(2'd0, 4'd5, 3'd1, 4'd2, 3'd0, 4'hC);
        dif.state_info = {3'd0, 3'd6};
        run_frames(2);

        random_phase(40);
        run_frames(1);

        // asynchronous reset while digit 2 is being driven
        wait_frame_pos(2 * DIV + 3);
        @(posedge clk);
        #1 rstn = 1'b0;
        sb.delete();
        #1 compare(get_out(), '0, "async_reset");
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        run_frames(2);

        random_phase(15);
        run_frames(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
